widths_byte_serializer: RTL and testbench

- Downstream stage of the 16-bit union splitter. Consumes the split low/high bytes as one word per valid/ready beat and emits them as an 8-bit byte stream, two beats per word.
- Buffers up to DEPTH words so the byte sink can stall without back-pressuring the splitter every other cycle.
- Feeds the byte-wide output path; keeps a wrap-around count of words fully emitted, for debug visibility.

---
 rtl/widths_pkg.sv | 26 ++
 rtl/widths_word_fifo.sv | 74 +++++++
 rtl/widths_byte_serializer.sv | 88 ++++++++
 tb/tb_widths_byte_serializer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/widths_pkg.sv
// Shared types for the byte-width serializer slice.
//   byte_t        : one byte lane
//   word_t        : a split 16-bit word as {high, low}
//   byte_phase_e  : which byte of the head word is on the output
//   pick_byte()   : maps phase + HIGH_FIRST onto a byte lane of a word
package widths_pkg;

  typedef logic [7:0] byte_t;

  typedef struct packed {
    byte_t high;
    byte_t low;
  } word_t;

  typedef enum logic {PH_FIRST, PH_SECOND} byte_phase_e;

  localparam int BYTES_PER_WORD = 2;

  // The first beat carries low unless high_first; the second beat carries
  // the other lane, so the choice is simply second XOR high_first.
  function automatic byte_t pick_byte(input word_t w, input logic second,
                                      input logic high_first);
    return (second ^ high_first) ? w.high : w.low;
  endfunction

endpackage

// File: rtl/widths_word_fifo.sv
// Word FIFO with registered storage and no fall-through.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush_i    : synchronous clear of pointers and occupancy
//   push_i     : write wdata_i (ignored when full or flushing)
//   wdata_i    : word to store
//   pop_i      : drop the head entry (ignored when empty or flushing)
//   rdata_o    : head entry, read from storage registers
//   full_o     : occupancy == DEPTH
//   empty_o    : occupancy == 0
//   fill_o     : occupancy
module widths_word_fifo
  import widths_pkg::*;
#(
  parameter int  DEPTH  = 4,
  parameter type data_t = word_t
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  data_t                    wdata_i,
  input  logic                     pop_i,
  output data_t                    rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   fill_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = DEPTH[PW:0];

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  data_t         mem_q [DEPTH];

  logic push_ok, pop_ok;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign fill_o  = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A full FIFO refuses a push even when a pop happens in the same cycle,
  // which keeps full_o (and so in_ready upstream) free of any pop path.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; entries are only visible once counted in.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/widths_byte_serializer.sv
// Serializes split 16-bit words into a byte stream, two beats per word.
//   clk, rst_n           : clock, asynchronous active-low reset
//   flush                : synchronous drop of buffered words and byte phase
//   in_valid/in_ready    : word handshake; in_low/in_high sampled on push
//   out_valid/out_ready  : byte handshake; out_data is the current byte,
//                          out_last marks the second byte of a word
//   word_cnt             : words fully emitted, wraps modulo 2^CNT_W
//   fill                 : words buffered
// Handshakes: a beat transfers on a cycle where valid && ready are both high
// at the rising edge; valid is never a function of ready on either side.
module widths_byte_serializer
  import widths_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter bit HIGH_FIRST = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_low,
  input  logic [7:0]             in_high,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_data,
  output logic                   out_last,
  output logic [CNT_W-1:0]       word_cnt,
  output logic [$clog2(DEPTH):0] fill
);

  logic        fifo_full, fifo_empty;
  word_t       head, wdata;
  byte_phase_e phase_q;
  logic [CNT_W-1:0] word_cnt_q;
  logic        byte_hs, word_done;

  assign wdata = '{high: in_high, low: in_low};

  widths_word_fifo #(
    .DEPTH  (DEPTH),
    .data_t (word_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (in_valid),
    .wdata_i (wdata),
    .pop_i   (word_done),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .fill_o  (fill)
  );

  // Both sides derive from the FIFO occupancy register only.
  assign in_ready  = !fifo_full;
  assign out_valid = !fifo_empty;

  assign byte_hs   = out_valid && out_ready;
  assign word_done = byte_hs && (phase_q == PH_SECOND);

  // Phase FSM and emitted-word counter. A flush wins over any handshake in
  // the same cycle, so a half-sent word is never counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= PH_FIRST;
      word_cnt_q <= '0;
    end else if (flush) begin
      phase_q    <= PH_FIRST;
    end else if (byte_hs) begin
      if (phase_q == PH_FIRST) begin
        phase_q <= PH_SECOND;
      end else begin
        phase_q    <= PH_FIRST;
        word_cnt_q <= word_cnt_q + 1'b1;
      end
    end
  end

  // Head and phase only change on a handshake, so these hold under stall.
  assign out_data = out_valid ? pick_byte(head, phase_q == PH_SECOND, HIGH_FIRST)
                              : 8'h00;
  assign out_last = (phase_q == PH_SECOND);
  assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_widths_byte_serializer.sv
module tb_widths_byte_serializer;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_low, in_high;
  logic       out_ready;

  // default DUT (DEPTH=4, low first, 16-bit counter)
  logic        in_ready_0, out_valid_0, out_last_0;
  logic [7:0]  out_data_0;
  logic [15:0] word_cnt_0;
  logic [2:0]  fill_0;
  // HIGH_FIRST=1 DUT
  logic        in_ready_h, out_valid_h, out_last_h;
  logic [7:0]  out_data_h;
  logic [15:0] word_cnt_h;
  logic [2:0]  fill_h;
  // CNT_W=4 DUT
  logic        in_ready_c, out_valid_c, out_last_c;
  logic [7:0]  out_data_c;
  logic [3:0]  word_cnt_c;
  logic [2:0]  fill_c;

  int total = 0;
  int bad   = 0;
  int sent  = 0;
  int bytes_seen = 0;
  logic [7:0] exp_q[$];

  widths_byte_serializer #(.DEPTH(4), .HIGH_FIRST(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready_0), .in_low(in_low), .in_high(in_high),
    .out_valid(out_valid_0), .out_ready(out_ready), .out_data(out_data_0),
    .out_last(out_last_0), .word_cnt(word_cnt_0), .fill(fill_0)
  );

  widths_byte_serializer #(.DEPTH(4), .HIGH_FIRST(1'b1), .CNT_W(16)) dut_hf (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready_h), .in_low(in_low), .in_high(in_high),
    .out_valid(out_valid_h), .out_ready(out_ready), .out_data(out_data_h),
    .out_last(out_last_h), .word_cnt(word_cnt_h), .fill(fill_h)
  );

  widths_byte_serializer #(.DEPTH(4), .HIGH_FIRST(1'b0), .CNT_W(4)) dut_c4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready_c), .in_low(in_low), .in_high(in_high),
    .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c),
    .out_last(out_last_c), .word_cnt(word_cnt_c), .fill(fill_c)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance to 1 time unit after the next rising edge
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_low    = 8'h00;
    in_high   = 8'h00;
    out_ready = 1'b0;
    sent      = 0;
    bytes_seen = 0;
    exp_q.delete();
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  // ---------------- directed word vectors ----------------
  function automatic logic [7:0] lo_of(input int i);
    return 8'h30 + i[7:0];
  endfunction

  function automatic logic [7:0] hi_of(input int i);
    return 8'hC0 + i[7:0];
  endfunction

  // ---------------- driver + scoreboard ----------------
  // Offers words sent..n_words-1, checks every accepted byte of dut0 and
  // dut_c4 against exp_q, until all words are in and all bytes are out.
  task automatic run_until_drained(input int n_words, input int budget);
    logic [7:0] exp_b;
    int cyc = 0;
    while ((sent < n_words || exp_q.size() != 0) && cyc < budget) begin
      in_valid = (sent < n_words);
      in_low   = lo_of(sent);
      in_high  = hi_of(sent);
      if (out_valid_0 && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_extra_byte: got %h want none", out_data_0);
        end else begin
          exp_b = exp_q.pop_front();
          bytes_seen++;
          if (out_data_0 !== exp_b) begin
            bad++;
            $display("FAIL sb_byte: got %h want %h", out_data_0, exp_b);
          end
          total++;
          if (out_data_c !== exp_b) begin
            bad++;
            $display("FAIL sb_byte_c4: got %h want %h", out_data_c, exp_b);
          end
        end
      end
      if (in_valid && in_ready_0) begin
        exp_q.push_back(lo_of(sent));
        exp_q.push_back(hi_of(sent));
        sent++;
      end
      cycle();
      cyc++;
    end
    in_valid = 1'b0;
    total++;
    if (sent < n_words || exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_timeout: got sent=%0d pending=%0d want sent=%0d pending=0",
               sent, exp_q.size(), n_words);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    total++; if (in_ready_0 !== 1'b1)   begin bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready_0); end
    total++; if (out_valid_0 !== 1'b0)  begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid_0); end
    total++; if (out_data_0 !== 8'h00)  begin bad++; $display("FAIL rst_out_data: got %h want 00", out_data_0); end
    total++; if (out_last_0 !== 1'b0)   begin bad++; $display("FAIL rst_out_last: got %b want 0", out_last_0); end
    total++; if (word_cnt_0 !== 16'd0)  begin bad++; $display("FAIL rst_word_cnt: got %0d want 0", word_cnt_0); end
    total++; if (fill_0 !== 3'd0)       begin bad++; $display("FAIL rst_fill: got %0d want 0", fill_0); end
  endtask

  task automatic test_single_word();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_low    = 8'h34;
    in_high   = 8'h12;
    cycle();                       // push at this edge (cycle N)
    in_valid = 1'b0;
    // N+1: first byte
    total++; if (out_valid_0 !== 1'b1) begin bad++; $display("FAIL single_valid_n1: got %b want 1", out_valid_0); end
    total++; if (out_data_0 !== 8'h34) begin bad++; $display("FAIL single_b0: got %h want 34", out_data_0); end
    total++; if (out_last_0 !== 1'b0)  begin bad++; $display("FAIL single_last0: got %b want 0", out_last_0); end
    total++; if (out_data_h !== 8'h12) begin bad++; $display("FAIL hf_b0: got %h want 12", out_data_h); end
    total++; if (out_last_h !== 1'b0)  begin bad++; $display("FAIL hf_last0: got %b want 0", out_last_h); end
    cycle();
    // N+2: second byte
    total++; if (out_data_0 !== 8'h12) begin bad++; $display("FAIL single_b1: got %h want 12", out_data_0); end
    total++; if (out_last_0 !== 1'b1)  begin bad++; $display("FAIL single_last1: got %b want 1", out_last_0); end
    total++; if (out_data_h !== 8'h34) begin bad++; $display("FAIL hf_b1: got %h want 34", out_data_h); end
    total++; if (out_last_h !== 1'b1)  begin bad++; $display("FAIL hf_last1: got %b want 1", out_last_h); end
    total++; if (word_cnt_0 !== 16'd0) begin bad++; $display("FAIL single_cnt_mid: got %0d want 0", word_cnt_0); end
    cycle();
    total++; if (word_cnt_0 !== 16'd1) begin bad++; $display("FAIL single_cnt: got %0d want 1", word_cnt_0); end
    total++; if (word_cnt_h !== 16'd1) begin bad++; $display("FAIL hf_cnt: got %0d want 1", word_cnt_h); end
    total++; if (out_valid_0 !== 1'b0) begin bad++; $display("FAIL single_drained: got %b want 0", out_valid_0); end
    out_ready = 1'b0;
  endtask

  task automatic test_fill_stall();
    int cyc = 0;
    do_reset();
    out_ready = 1'b0;
    while (sent < 4 && cyc < 10) begin
      in_valid = 1'b1;
      in_low   = lo_of(sent);
      in_high  = hi_of(sent);
      if (in_ready_0) begin
        exp_q.push_back(lo_of(sent));
        exp_q.push_back(hi_of(sent));
        sent++;
      end
      cycle();
      cyc++;
    end
    // fifth word offered and held off
    in_valid = 1'b1;
    in_low   = lo_of(4);
    in_high  = hi_of(4);
    total++; if (fill_0 !== 3'd4)      begin bad++; $display("FAIL full_fill: got %0d want 4", fill_0); end
    total++; if (in_ready_0 !== 1'b0)  begin bad++; $display("FAIL full_in_ready: got %b want 0", in_ready_0); end
    repeat (2) cycle();
    total++; if (fill_0 !== 3'd4)      begin bad++; $display("FAIL full_hold_fill: got %0d want 4", fill_0); end
    total++; if (out_data_0 !== 8'h30) begin bad++; $display("FAIL full_head: got %h want 30", out_data_0); end
    out_ready = 1'b1;
    run_until_drained(5, 60);
    total++; if (word_cnt_0 !== 16'd5) begin bad++; $display("FAIL fill_cnt: got %0d want 5", word_cnt_0); end
    total++; if (bytes_seen != 10)     begin bad++; $display("FAIL fill_bytes: got %0d want 10", bytes_seen); end
    out_ready = 1'b0;
  endtask

  task automatic test_stall_mid_word();
    do_reset();
    in_valid = 1'b1;
    in_low   = 8'hA5;
    in_high  = 8'h5A;
    cycle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();                       // first byte taken, now in second phase
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++; if (out_data_0 !== 8'h5A) begin bad++; $display("FAIL stall_data[%0d]: got %h want 5a", k, out_data_0); end
      total++; if (out_last_0 !== 1'b1)  begin bad++; $display("FAIL stall_last[%0d]: got %b want 1", k, out_last_0); end
      total++; if (fill_0 !== 3'd1)      begin bad++; $display("FAIL stall_fill[%0d]: got %0d want 1", k, fill_0); end
      total++; if (word_cnt_0 !== 16'd0) begin bad++; $display("FAIL stall_cnt[%0d]: got %0d want 0", k, word_cnt_0); end
      cycle();
    end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    total++; if (word_cnt_0 !== 16'd1) begin bad++; $display("FAIL stall_cnt_after: got %0d want 1", word_cnt_0); end
    total++; if (fill_0 !== 3'd0)      begin bad++; $display("FAIL stall_fill_after: got %0d want 0", fill_0); end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_low   = lo_of(i);
      in_high  = hi_of(i);
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();
    total++; if (out_last_0 !== 1'b1) begin bad++; $display("FAIL flush_pre_last: got %b want 1", out_last_0); end
    total++; if (fill_0 !== 3'd3)     begin bad++; $display("FAIL flush_pre_fill: got %0d want 3", fill_0); end
    // flush with a same-cycle push and a same-cycle final-byte handshake
    flush    = 1'b1;
    in_valid = 1'b1;
    in_low   = lo_of(9);
    in_high  = hi_of(9);
    cycle();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    total++; if (fill_0 !== 3'd0)      begin bad++; $display("FAIL flush_fill: got %0d want 0", fill_0); end
    total++; if (out_valid_0 !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b want 0", out_valid_0); end
    total++; if (out_last_0 !== 1'b0)  begin bad++; $display("FAIL flush_last: got %b want 0", out_last_0); end
    total++; if (word_cnt_0 !== 16'd0) begin bad++; $display("FAIL flush_cnt: got %0d want 0", word_cnt_0); end
    cycle();
    total++; if (fill_0 !== 3'd0)      begin bad++; $display("FAIL flush_push_dropped: got %0d want 0", fill_0); end
    in_valid = 1'b1;
    in_low   = lo_of(7);
    in_high  = hi_of(7);
    cycle();
    in_valid = 1'b0;
    total++; if (out_data_0 !== 8'h37) begin bad++; $display("FAIL flush_next_word: got %h want 37", out_data_0); end
    total++; if (out_last_0 !== 1'b0)  begin bad++; $display("FAIL flush_next_last: got %b want 0", out_last_0); end
  endtask

  task automatic test_reset_mid_word();
    do_reset();
    in_valid = 1'b1;
    in_low   = lo_of(3);
    in_high  = hi_of(3);
    cycle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    total++; if (out_last_0 !== 1'b1) begin bad++; $display("FAIL rmw_pre_last: got %b want 1", out_last_0); end
    #2;
    rst_n = 1'b0;                  // asynchronous, away from any edge
    #1;
    total++; if (out_last_0 !== 1'b0)  begin bad++; $display("FAIL rmw_last: got %b want 0", out_last_0); end
    total++; if (fill_0 !== 3'd0)      begin bad++; $display("FAIL rmw_fill: got %0d want 0", fill_0); end
    total++; if (out_valid_0 !== 1'b0) begin bad++; $display("FAIL rmw_valid: got %b want 0", out_valid_0); end
    total++; if (word_cnt_0 !== 16'd0) begin bad++; $display("FAIL rmw_cnt: got %0d want 0", word_cnt_0); end
    cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_back_to_back_wrap();
    do_reset();
    out_ready = 1'b1;
    run_until_drained(17, 200);
    total++; if (word_cnt_c !== 4'd1)   begin bad++; $display("FAIL wrap_cnt4: got %0d want 1", word_cnt_c); end
    total++; if (word_cnt_0 !== 16'd17) begin bad++; $display("FAIL wrap_cnt16: got %0d want 17", word_cnt_0); end
    total++; if (bytes_seen != 34)      begin bad++; $display("FAIL wrap_bytes: got %0d want 34", bytes_seen); end
    total++; if (out_valid_0 !== 1'b0)  begin bad++; $display("FAIL wrap_drained: got %b want 0", out_valid_0); end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_fill_stall();
    test_stall_mid_word();
    test_flush();
    test_reset_mid_word();
    test_back_to_back_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
